// File: rtl/mpei_ahb_arb2.sv
// Two-port AHB-Lite arbiter: per-port one-deep address holding register,
// round-robin issue onto a shared slave bus, data phase routed to its owner.

module mpei_ahb_arb2_port #(
  parameter int HW = 40
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [1:0]    htrans,
  input  logic [HW-1:0] hfields,
  input  logic          gnt_i,
  input  logic          s_hready,
  input  logic          s_hresp,
  output logic          pend_o,
  output logic          hready_o,
  output logic          hresp_o,
  output logic [HW-1:0] held_o
);
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DATA} st_t;

  st_t           st_q, st_d;
  logic [HW-1:0] held_q, held_d;
  logic          cap;

  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    case (st_q)
      S_PEND:  hready_o = 1'b0;
      S_DATA:  begin hready_o = s_hready; hresp_o = s_hresp; end
      default: ;
    endcase
    // BUSY/IDLE never capture; SEQ is treated like NONSEQ
    cap    = hready_o & (htrans inside {2'b10, 2'b11});
    st_d   = st_q;
    held_d = held_q;
    case (st_q)
      S_IDLE:  if (cap) st_d = S_PEND;
      S_PEND:  if (gnt_i && s_hready) st_d = S_DATA;
      S_DATA:  if (s_hready) st_d = cap ? S_PEND : S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (cap) held_d = hfields;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_q   <= S_IDLE;
      held_q <= '0;
    end else begin
      st_q   <= st_d;
      held_q <= held_d;
    end
  end

  assign pend_o = (st_q == S_PEND);
  assign held_o = held_q;
endmodule

module mpei_ahb_arb2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [3:0]    m0_hprot,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [3:0]    m1_hprot,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [3:0]    s_hprot,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic          s_hresp
);
  localparam int HW = AW + 8;

  logic [1:0][HW-1:0] mf, held;
  logic [1:0][1:0]    mt;
  logic [1:0]         pend, gnt, hready, hresp;

  logic          any, sel, issue;
  logic          hold_q, hold_d, hold_gnt_q, hold_gnt_d;
  logic          last_q, last_d, owner_q, owner_d;
  logic [HW-1:0] bus_q, bus_d;

  assign mf[0] = {m0_haddr, m0_hwrite, m0_hsize, m0_hprot};
  assign mf[1] = {m1_haddr, m1_hwrite, m1_hsize, m1_hprot};
  assign mt[0] = m0_htrans;
  assign mt[1] = m1_htrans;

  for (genvar g = 0; g < 2; g++) begin : g_port
    mpei_ahb_arb2_port #(.HW(HW)) u_port (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .htrans   (mt[g]),
      .hfields  (mf[g]),
      .gnt_i    (gnt[g]),
      .s_hready (s_hready),
      .s_hresp  (s_hresp),
      .pend_o   (pend[g]),
      .hready_o (hready[g]),
      .hresp_o  (hresp[g]),
      .held_o   (held[g])
    );
  end

  always_comb begin
    any = |pend;
    // a stalled address phase keeps its grant until the slave accepts it
    if (hold_q)      sel = hold_gnt_q;
    else if (&pend)  sel = ~last_q;
    else             sel = pend[1];
    gnt        = any ? (sel ? 2'b10 : 2'b01) : 2'b00;
    issue      = any & s_hready;
    hold_d     = any & ~s_hready;
    hold_gnt_d = sel;
    last_d     = issue ? sel : last_q;
    owner_d    = issue ? sel : owner_q;
    bus_d      = any ? held[sel] : bus_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_q     <= 1'b0;
      hold_gnt_q <= 1'b0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      bus_q      <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_gnt_q <= hold_gnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      bus_q      <= bus_d;
    end
  end

  assign {s_haddr, s_hwrite, s_hsize, s_hprot} = bus_d;
  assign s_htrans  = any ? 2'b10 : 2'b00;
  assign s_hwdata  = owner_q ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hready = hready[0];
  assign m1_hready = hready[1];
  assign m0_hresp  = hresp[0];
  assign m1_hresp  = hresp[1];
endmodule

// File: tb/tb_mpei_ahb_arb2.sv
// Bench for mpei_ahb_arb2: two AHB masters, a configurable slave and a
// grant-ordered scoreboard of per-port address queues.

module tb_mpei_ahb_arb2;
  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0][31:0]  m_haddr, m_hwdata, m_hrdata;
  logic [1:0][1:0]   m_htrans;
  logic [1:0]        m_hwrite, m_hready, m_hresp;
  logic [1:0][2:0]   m_hsize;
  logic [1:0][3:0]   m_hprot;
  logic [31:0]       s_haddr, s_hwdata, s_hrdata;
  logic [1:0]        s_htrans;
  logic              s_hwrite, s_hready, s_hresp;
  logic [2:0]        s_hsize;
  logic [3:0]        s_hprot;

  always #5 clk = ~clk;

  mpei_ahb_arb2 #(.AW(32), .DW(32)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m0_haddr(m_haddr[0]), .m0_htrans(m_htrans[0]), .m0_hwrite(m_hwrite[0]),
    .m0_hsize(m_hsize[0]), .m0_hprot(m_hprot[0]), .m0_hwdata(m_hwdata[0]),
    .m0_hrdata(m_hrdata[0]), .m0_hready(m_hready[0]), .m0_hresp(m_hresp[0]),
    .m1_haddr(m_haddr[1]), .m1_htrans(m_htrans[1]), .m1_hwrite(m_hwrite[1]),
    .m1_hsize(m_hsize[1]), .m1_hprot(m_hprot[1]), .m1_hwdata(m_hwdata[1]),
    .m1_hrdata(m_hrdata[1]), .m1_hready(m_hready[1]), .m1_hresp(m_hresp[1]),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  typedef struct { logic [31:0] addr; logic wr; } xfer_t;

  xfer_t       q0[$], q1[$];
  int          exp_gnt[$];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  int          acc_cyc[2], cmp_cyc[2];
  logic        dpv;
  xfer_t       dp;
  int          dp_p, wcnt;
  logic        samp_rdy, samp_acc, samp_wr;
  logic [31:0] samp_addr;
  logic [31:0] wait_addr, err_addr;
  int          wait_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : ~a;
  endfunction

  function automatic logic [31:0] f_wd(input logic [31:0] a);
    return (a == 32'h10) ? 32'h11 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic int exp_waits(input logic [31:0] a);
    if (a == wait_addr) return wait_n;
    if (a == err_addr)  return 1;
    return 0;
  endfunction

  // Slave: data phase starts the cycle after an accepted address phase.
  task automatic slave_loop();
    logic        act, w, err;
    logic [31:0] a;
    int          cnt, ec;
    act = 0; w = 0; err = 0; a = '0; cnt = 0; ec = 0;
    forever begin
      @(posedge clk); #1;
      s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
      if (!rstn) begin act = 0; continue; end
      if (samp_rdy) begin
        act = samp_acc; a = samp_addr; w = samp_wr;
        cnt = (samp_addr == wait_addr) ? wait_n : 0;
        err = (samp_addr == err_addr); ec = 0;
      end
      if (act) begin
        if (err) begin s_hresp = 1'b1; s_hready = (ec != 0); ec++; end
        else if (cnt > 0) begin s_hready = 1'b0; cnt--; end
        if (!w) s_hrdata = f_rd(a);
      end
    end
  endtask

  task automatic mon_loop();
    logic        prev_stall;
    logic [31:0] prev_addr;
    xfer_t       e;
    int          p;
    prev_stall = 0; prev_addr = '0;
    forever begin
      @(negedge clk); cyc++;
      if (!rstn) begin
        prev_stall = 0; dpv = 0; samp_rdy = 1; samp_acc = 0;
        continue;
      end
      samp_rdy = s_hready; samp_acc = s_htrans[1] & s_hready;
      samp_addr = s_haddr; samp_wr = s_hwrite;
      if (prev_stall) begin
        chk("stall_htrans", {30'd0, s_htrans}, 32'd2);
        chk("stall_haddr", s_haddr, prev_addr);
      end
      prev_stall = s_htrans[1] & ~s_hready;
      prev_addr  = s_haddr;
      if (dpv) begin
        chk("dp_hresp", {31'd0, m_hresp[dp_p]}, {31'd0, (dp.addr == err_addr)});
        chk("other_hresp", {31'd0, m_hresp[1-dp_p]}, 32'd0);
        if (!s_hready) begin
          chk("dp_wait_hready", {31'd0, m_hready[dp_p]}, 32'd0);
          wcnt++;
        end else begin
          chk("dp_hready", {31'd0, m_hready[dp_p]}, 32'd1);
          chk("dp_waits", wcnt, exp_waits(dp.addr));
          if (dp.wr) chk("s_hwdata", s_hwdata, f_wd(dp.addr));
          else       chk("m_hrdata", m_hrdata[dp_p], f_rd(dp.addr));
          cmp_cyc[dp_p] = cyc;
          dpv = 0;
        end
      end
      if (s_htrans[1] && s_hready) begin
        if (exp_gnt.size() == 0) chk("unexpected_issue", s_haddr, 32'hFFFF_FFFF);
        else begin
          p = exp_gnt.pop_front();
          if ((p == 0 ? q0.size() : q1.size()) == 0) chk("issue_port_empty", p, 32'hFFFF_FFFF);
          else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk("s_haddr", s_haddr, e.addr);
            chk("s_hwrite", {31'd0, s_hwrite}, {31'd0, e.wr});
            chk("s_htrans_nonseq", {30'd0, s_htrans}, 32'd2);
            dp = e; dp_p = p; dpv = 1; wcnt = 0; acc_cyc[p] = cyc;
          end
        end
      end
      // a master address is taken when presented with its hready high
      for (int i = 0; i < 2; i++)
        if (m_htrans[i][1] && m_hready[i]) begin
          e.addr = m_haddr[i]; e.wr = m_hwrite[i];
          if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
    end
  endtask

  task automatic master(input int p, input int n, input logic [31:0] base, input logic wr);
    logic rdy;
    int   t;
    for (int i = 0; i < n; i++) begin
      m_htrans[p] = 2'b10; m_haddr[p] = base + 32'(4 * i); m_hwrite[p] = wr;
      rdy = 0; t = 0;
      while (!rdy && t < 200) begin
        @(negedge clk); rdy = m_hready[p];
        @(posedge clk); #1; t++;
      end
      if (!rdy) chk("master_accept_timeout", 32'd0, 32'd1);
      m_hwdata[p] = f_wd(m_haddr[p]);
    end
    m_htrans[p] = 2'b00;
    rdy = 0; t = 0;
    while (!rdy && t < 200) begin @(negedge clk); rdy = m_hready[p]; t++; end
    if (!rdy) chk("master_done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic clear_sb();
    q0.delete(); q1.delete(); exp_gnt.delete(); dpv = 0;
  endtask

  task automatic do_reset();
    m_htrans = '0; rstn = 1'b0; clear_sb();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || dpv) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("drain", q0.size() + q1.size() + exp_gnt.size() + int'(dpv), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_haddr = '0; m_hwdata = '0; m_htrans = '0; m_hwrite = '0;
    m_hsize = {3'd2, 3'd2}; m_hprot = {4'h3, 4'h3};
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    samp_rdy = 1; samp_acc = 0; samp_wr = 0; samp_addr = '0;
    wait_addr = '1; err_addr = '1; wait_n = 0; dpv = 0; dp_p = 0; wcnt = 0;
    dp = '{addr: '0, wr: 1'b0};
    acc_cyc = '{0, 0}; cmp_cyc = '{0, 0};
    rstn = 1'b1;
    fork
      slave_loop();
      mon_loop();
    join_none
    #1 rstn = 1'b0;
    #1;
    chk("rst_s_htrans", {30'd0, s_htrans}, 32'd0);
    chk("rst_s_haddr", s_haddr, 32'd0);
    chk("rst_m_hready", {30'd0, m_hready}, 32'd3);
    chk("rst_m_hresp", {30'd0, m_hresp}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // port 0 single read, zero-wait slave
    exp_gnt.push_back(0);
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h100; m_hwrite[0] = 1'b0;
    @(negedge clk);
    chk("t1_m0_hready_addr", {31'd0, m_hready[0]}, 32'd1);
    @(posedge clk); #1 m_htrans[0] = 2'b00;
    @(negedge clk);
    chk("t1_s_htrans", {30'd0, s_htrans}, 32'd2);
    chk("t1_s_haddr", s_haddr, 32'h100);
    chk("t1_m0_hready_pend", {31'd0, m_hready[0]}, 32'd0);
    chk("t1_m1_hready_a", {31'd0, m_hready[1]}, 32'd1);
    @(negedge clk);
    chk("t1_m0_hready_data", {31'd0, m_hready[0]}, 32'd1);
    chk("t1_m0_hrdata", m_hrdata[0], 32'hDEAD_BEEF);
    chk("t1_m1_hready_b", {31'd0, m_hready[1]}, 32'd1);
    chk("t1_s_htrans_idle", {30'd0, s_htrans}, 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // simultaneous NONSEQ on both ports
    do_reset();
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      master(0, 1, 32'h10, 1'b1);
      master(1, 1, 32'h20, 1'b0);
    join
    wait_idle();
    chk("t2_p1_next_cycle", acc_cyc[1], acc_cyc[0] + 1);

    // continuous traffic on both ports, strict alternation
    do_reset();
    for (int i = 0; i < 16; i++) exp_gnt.push_back(i % 2);
    fork
      master(0, 8, 32'h1000, 1'b1);
      master(1, 8, 32'h2000, 1'b0);
    join
    wait_idle();

    // 3 wait states on a port 1 read while port 0 waits
    do_reset();
    wait_addr = 32'h300; wait_n = 3;
    exp_gnt.push_back(1); exp_gnt.push_back(0);
    fork
      master(1, 1, 32'h300, 1'b0);
      begin @(posedge clk); #1; master(0, 1, 32'h400, 1'b0); end
    join
    wait_idle();
    chk("t4_issue_on_complete", acc_cyc[0], cmp_cyc[1]);
    wait_addr = '1;

    // ERROR response to port 0
    do_reset();
    err_addr = 32'h500;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      master(0, 1, 32'h500, 1'b0);
      master(1, 1, 32'h504, 1'b0);
    join
    wait_idle();
    err_addr = '1;

    // reset while port 1 is stalled in its data phase
    do_reset();
    wait_addr = 32'h600; wait_n = 8;
    exp_gnt.push_back(1);
    m_htrans[1] = 2'b10; m_haddr[1] = 32'h600; m_hwrite[1] = 1'b0;
    @(posedge clk); #1 m_htrans[1] = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_m1_stalled", {31'd0, m_hready[1]}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_s_htrans", {30'd0, s_htrans}, 32'd0);
    chk("t6_m_hready", {30'd0, m_hready}, 32'd3);
    chk("t6_m_hresp", {30'd0, m_hresp}, 32'd0);
    clear_sb();
    wait_addr = '1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      master(0, 1, 32'h700, 1'b0);
      master(1, 1, 32'h704, 1'b0);
    join
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
